// File: rtl/apu_sweep_bank.sv
// Multi-channel pulse sweep engine: owns each channel's timer period and sweep
// config, and steps one channel per clock after every half-frame tick.
module apu_sweep_bank #(
    parameter int                NUM_CH         = 2,
    parameter int                PERIOD_W       = 11,
    parameter logic [NUM_CH-1:0] ONES_COMP_MASK = 2'b01,
    localparam int               CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halfframe,
    input  logic                       wr_en,
    input  logic [CH_W-1:0]            wr_ch,
    input  logic [1:0]                 wr_sel,
    input  logic [7:0]                 wr_data,
    output logic [NUM_CH*PERIOD_W-1:0] period_o,
    output logic [NUM_CH-1:0]          mute_o,
    output logic                       busy
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

    localparam logic [CH_W-1:0]     LAST_IDX = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]     ONE_IDX  = CH_W'(1);
    localparam logic [PERIOD_W-1:0] ONE_P    = PERIOD_W'(1);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                pending_q, pending_d;

    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] period_d [NUM_CH];
    logic [2:0]          divp_q   [NUM_CH];
    logic [2:0]          divp_d   [NUM_CH];
    logic [2:0]          shift_q  [NUM_CH];
    logic [2:0]          shift_d  [NUM_CH];
    logic [2:0]          div_q    [NUM_CH];
    logic [2:0]          div_d    [NUM_CH];
    logic [NUM_CH-1:0]   en_q, en_d;
    logic [NUM_CH-1:0]   neg_q, neg_d;
    logic [NUM_CH-1:0]   reload_q, reload_d;

    logic [PERIOD_W-1:0] change   [NUM_CH];
    logic [PERIOD_W:0]   addend   [NUM_CH];
    logic [PERIOD_W:0]   sum      [NUM_CH];
    logic [PERIOD_W-1:0] target   [NUM_CH];
    logic [NUM_CH-1:0]   overflow;
    logic [NUM_CH-1:0]   mute;
    logic                scan_active;

    // Sweep target per channel; a negative sweep that underflows clamps to 0
    // rather than reporting overflow.
    always_comb begin
        overflow = '0;
        mute     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            change[c] = period_q[c] >> shift_q[c];
            if (!neg_q[c]) begin
                addend[c] = {1'b0, change[c]};
            end else if (ONES_COMP_MASK[c]) begin
                addend[c] = {1'b1, ~change[c]};
            end else begin
                addend[c] = {1'b1, ~change[c] + ONE_P};
            end
            sum[c] = {1'b0, period_q[c]} + addend[c];
            if (neg_q[c] && sum[c][PERIOD_W]) begin
                target[c]   = '0;
                overflow[c] = 1'b0;
            end else begin
                target[c]   = sum[c][PERIOD_W-1:0];
                overflow[c] = sum[c][PERIOD_W];
            end
            mute[c] = (period_q[c][PERIOD_W-1:3] == '0) | overflow[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // A tick during a scan is remembered once; the last channel either ends
    // the scan or starts the next one straight away.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (halfframe) begin
                    state_d   = ST_SCAN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    if (pending_q || halfframe) begin
                        idx_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + ONE_IDX;
                    if (halfframe) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_active = (state_q == ST_SCAN);
        busy        = scan_active;
    end

    // Scan step first, CPU write second, so the write wins on a collision.
    always_comb begin
        en_d     = en_q;
        neg_d    = neg_q;
        reload_d = reload_q;
        for (int c = 0; c < NUM_CH; c++) begin
            period_d[c] = period_q[c];
            divp_d[c]   = divp_q[c];
            shift_d[c]  = shift_q[c];
            div_d[c]    = div_q[c];
            if (scan_active && (int'(idx_q) == c)) begin
                if ((div_q[c] == 3'd0) && en_q[c] && !mute[c] && (shift_q[c] != 3'd0)) begin
                    period_d[c] = target[c];
                end
                if ((div_q[c] == 3'd0) || reload_q[c]) begin
                    div_d[c]    = divp_q[c];
                    reload_d[c] = 1'b0;
                end else begin
                    div_d[c] = div_q[c] - 3'd1;
                end
            end
            if (wr_en && (int'(wr_ch) == c)) begin
                case (wr_sel)
                    2'd0: begin
                        en_d[c]     = wr_data[7];
                        divp_d[c]   = wr_data[6:4];
                        neg_d[c]    = wr_data[3];
                        shift_d[c]  = wr_data[2:0];
                        reload_d[c] = 1'b1;
                    end
                    2'd1: period_d[c][7:0] = wr_data;
                    2'd2: period_d[c][PERIOD_W-1:8] = wr_data[PERIOD_W-9:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= '0;
            neg_q    <= '0;
            reload_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c] <= '0;
                divp_q[c]   <= '0;
                shift_q[c]  <= '0;
                div_q[c]    <= '0;
            end
        end else begin
            en_q     <= en_d;
            neg_q    <= neg_d;
            reload_q <= reload_d;
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c] <= period_d[c];
                divp_q[c]   <= divp_d[c];
                shift_q[c]  <= shift_d[c];
                div_q[c]    <= div_d[c];
            end
        end
    end

    always_comb begin
        period_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            period_o[c*PERIOD_W +: PERIOD_W] = period_q[c];
        end
        mute_o = mute;
    end

endmodule
